// File: rtl/posit_pkg.sv
// Shared constants and field types for posit<64,4> to binary64 conversion.
package posit_pkg;

    localparam int N     = 64;          // posit width (also binary64 width)
    localparam int ES    = 4;           // posit exponent field width
    localparam int RS    = 7;           // regime value width, signed k
    localparam int FS    = N - ES - 3;  // fraction width after the hidden 1
    localparam int DFS   = 52;          // binary64 fraction width
    localparam int DBIAS = 1023;        // binary64 exponent bias
    localparam int SW    = RS + ES;     // scale width: 16*k + expo, signed

    localparam logic [N-1:0]  QNAN64   = 64'h7FF8_0000_0000_0000;
    localparam logic [RS-1:0] MAXPOS_K = 7'd62;

    // Unpacked fields as delivered by the posit decoder (magnitude form).
    typedef struct packed {
        logic          sign;
        logic [RS-1:0] regi;
        logic [ES-1:0] expo;
        logic [FS-1:0] frac;
        logic          allone;
        logic          allzero;
    } posit_fields_t;

    // Stage-1 pipeline register: rounded mantissa plus signed scale.
    typedef struct packed {
        logic           valid;
        logic           sign;
        logic           zero;
        logic           nar;
        logic [SW-1:0]  scale;
        logic [DFS-1:0] mant;
    } p2d_s1_t;

    // 16*k + expo: expo fills the low ES bits exactly, so the product
    // and sum collapse into a concatenation of the two fields.
    function automatic logic [SW-1:0] posit_scale(input logic [RS-1:0] k,
                                                  input logic [ES-1:0] e);
        return {k, e};
    endfunction

endpackage

// File: rtl/p2d_round.sv
// Round-to-nearest-even of a posit fraction down to a binary64 mantissa.
// o_carry flags a mantissa overflow; the caller bumps its scale by one.
module p2d_round
    import posit_pkg::*;
(
    input  logic [FS-1:0]  i_frac,
    output logic [DFS-1:0] o_mant,
    output logic           o_carry
);

    localparam int GB = FS - DFS;  // number of discarded low bits

    logic w_guard;
    logic w_sticky;
    logic w_lsb;
    logic w_up;

    assign w_guard  = i_frac[GB-1];
    assign w_sticky = |i_frac[GB-2:0];
    assign w_lsb    = i_frac[GB];
    // Ties go up only when the kept LSB is odd.
    assign w_up     = w_guard & (w_sticky | w_lsb);

    // Increment the kept bits; an all-ones mantissa carries out and wraps to 0.
    always_comb begin
        {o_carry, o_mant} = {1'b0, i_frac[FS-1:GB]} + {{DFS{1'b0}}, w_up};
    end

endmodule

// File: rtl/posit_to_double_pipe.sv
// Two-stage posit<64,4> decoded-field to IEEE-754 binary64 converter.
// Stage 1 forms the scale and rounds the fraction; stage 2 resolves
// zero / NaR and packs the result. Valid/ready on both sides.
module posit_to_double_pipe
    import posit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [RS-1:0] in_regi,
    input  logic [ES-1:0] in_expo,
    input  logic [FS-1:0] in_frac,
    input  logic          in_allone,
    input  logic          in_allzero,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_nar
);

    posit_fields_t  w_in;
    logic [RS-1:0]  w_k;
    logic [ES-1:0]  w_e;
    logic [FS-1:0]  w_f;
    logic [DFS-1:0] w_mant;
    logic           w_carry;
    logic [SW-1:0]  w_scale;
    p2d_s1_t        w_s1_next;
    logic           w_s1_adv;
    logic           w_s2_adv;
    logic [10:0]    w_bexp;
    logic [N-1:0]   w_res;

    p2d_s1_t        r_s1;
    logic           r_s2_valid;
    logic [N-1:0]   r_out_data;
    logic           r_out_nar;

    // Pipeline advance: stage 2 moves when empty or drained, stage 1 when
    // stage 2 makes room or stage 1 is empty (no bubble when streaming).
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = w_s2_adv || !r_s1.valid;
    assign in_ready = w_s1_adv;

    // Gather decoder fields and apply the maxpos override.
    always_comb begin
        w_in.sign    = in_sign;
        w_in.regi    = in_regi;
        w_in.expo    = in_expo;
        w_in.frac    = in_frac;
        w_in.allone  = in_allone;
        w_in.allzero = in_allzero;
        w_k = w_in.regi;
        w_e = w_in.expo;
        w_f = w_in.frac;
        if (w_in.allone) begin
            w_k = MAXPOS_K;
            w_e = '0;
            w_f = '0;
        end
    end

    p2d_round u_round (
        .i_frac  (w_f),
        .o_mant  (w_mant),
        .o_carry (w_carry)
    );

    // Stage-1 next value: classification, scale with rounding carry.
    always_comb begin
        w_scale         = posit_scale(w_k, w_e) + {{(SW-1){1'b0}}, w_carry};
        w_s1_next.valid = 1'b1;
        w_s1_next.sign  = w_in.sign;
        w_s1_next.zero  = w_in.allzero && !w_in.sign;
        w_s1_next.nar   = w_in.allzero && w_in.sign;
        w_s1_next.scale = w_scale;
        w_s1_next.mant  = w_mant;
    end

    // Stage-1 register: load only on a real transfer so idle inputs never
    // reach state; hold everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
        end else if (w_s1_adv) begin
            if (in_valid) r_s1       <= w_s1_next;
            else          r_s1.valid <= 1'b0;
        end
    end

    // Stage-2 packing. Scale spans -992..1008, so the biased exponent is
    // always a normal 31..2031 and a modulo-2048 add is exact.
    always_comb begin
        w_bexp = r_s1.scale + 11'(DBIAS);
        w_res  = {r_s1.sign, w_bexp, r_s1.mant};
        if (r_s1.nar)       w_res = QNAN64;
        else if (r_s1.zero) w_res = '0;
    end

    // Output register: holds data steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_nar  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1.valid;
            if (r_s1.valid) begin
                r_out_data <= w_res;
                r_out_nar  <= r_s1.nar;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign out_nar   = r_out_nar;

endmodule

// File: tb/tb_posit_to_double_pipe.sv
// Scoreboard bench for posit_to_double_pipe. Inputs change 1 time unit after
// the rising edge; the monitor samples on the falling edge.
module tb_posit_to_double_pipe;
    import posit_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sign = 1'b0;
    logic [RS-1:0] in_regi = '0;
    logic [ES-1:0] in_expo = '0;
    logic [FS-1:0] in_frac = '0;
    logic          in_allone = 1'b0;
    logic          in_allzero = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_data;
    logic          out_nar;

    typedef struct {
        logic [63:0] d;
        logic        n;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic        cur_has_c = 1'b0;
    logic [63:0] cur_d = '0;
    logic        cur_n = 1'b0;
    bit          rand_done;

    posit_to_double_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_regi    (in_regi),
        .in_expo    (in_expo),
        .in_frac    (in_frac),
        .in_allone  (in_allone),
        .in_allzero (in_allzero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_nar    (out_nar)
    );

    always #5 clk = ~clk;

    // Value-level reference: (1 + f/2^57) * 2^(16k+e), rounded by the
    // simulator's own integer-to-real conversion (round-to-nearest-even).
    function automatic exp_t ref_model(input logic s, input logic [6:0] k,
                                       input logic [3:0] e, input logic [56:0] f,
                                       input logic ao, input logic az);
        exp_t   r;
        int     sc;
        longint m;
        real    v;
        if (az) begin
            r.d = s ? 64'h7FF8_0000_0000_0000 : 64'h0;
            r.n = s;
            return r;
        end
        if (ao) begin
            sc = 62 * 16;
            m  = longint'(1) <<< 57;
        end else begin
            sc = $signed(k) * 16 + int'(e);
            m  = (longint'(1) <<< 57) | longint'(f);
        end
        v = real'(m) / (2.0 ** 57);
        v = v * (2.0 ** sc);
        if (s) v = -v;
        r.d = $realtobits(v);
        r.n = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Monitor: ready rule, output compare (also while stalled), then pop/push.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checks++;
            if (in_ready !== (q.size() < 2 || out_ready)) begin
                errors++;
                $display("FAIL in_ready got %b want %b (held %0d)", in_ready,
                         (q.size() < 2 || out_ready), q.size());
            end
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_output got %h want none", out_data);
                end else begin
                    if (out_data !== q[0].d || out_nar !== q[0].n) begin
                        errors++;
                        $display("FAIL out got %h nar %b want %h nar %b",
                                 out_data, out_nar, q[0].d, q[0].n);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                if (cur_has_c) begin
                    e.d = cur_d;
                    e.n = cur_n;
                end else begin
                    e = ref_model(in_sign, in_regi, in_expo, in_frac, in_allone, in_allzero);
                end
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic s, input logic [6:0] k, input logic [3:0] e,
                        input logic [56:0] f, input logic ao, input logic az,
                        input logic hc, input logic [63:0] cd, input logic cn);
        int   n;
        logic acc;
        in_sign = s; in_regi = k; in_expo = e; in_frac = f;
        in_allone = ao; in_allzero = az;
        cur_has_c = hc; cur_d = cd; cur_n = cn;
        in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_frac = {$urandom, $urandom};
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got no accept want accept");
        end
    endtask

    task automatic send_rand();
        int          k;
        logic [63:0] f;
        logic        ao, az;
        k  = int'($urandom_range(0, 124)) - 62;
        f  = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) f[4:0] = 5'h10;  // exact tie
        az = ($urandom_range(0, 15) == 0);
        ao = !az && ($urandom_range(0, 15) == 0);
        send(1'($urandom), 7'(k), 4'($urandom), f[56:0], ao, az, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_nar", 64'(out_nar), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with fixed expected words
        send(0, 7'd0,   4'd0, 57'h0,  0, 0, 1, 64'h3FF0_0000_0000_0000, 0);
        send(0, 7'd0,   4'd0, 57'h10, 0, 0, 1, 64'h3FF0_0000_0000_0000, 0);
        send(0, 7'd0,   4'd0, 57'h30, 0, 0, 1, 64'h3FF0_0000_0000_0002, 0);
        send(0, 7'd0,   4'd0, {57{1'b1}}, 0, 0, 1, 64'h4000_0000_0000_0000, 0);
        send(0, 7'd5,   4'd3, 57'h0,  0, 1, 1, 64'h0, 0);
        send(1, 7'd5,   4'd3, 57'h0,  0, 1, 1, 64'h7FF8_0000_0000_0000, 1);
        send(0, 7'd3,   4'd9, 57'h55, 1, 0, 1, 64'h7DF0_0000_0000_0000, 0);
        send(0, 7'h42,  4'd0, 57'h0,  0, 0, 1, 64'h01F0_0000_0000_0000, 0);
        send(1, 7'h42,  4'd0, 57'h0,  0, 0, 1, 64'h81F0_0000_0000_0000, 0);
        drain("drain_directed");

        // Backpressure: six back-to-back items, output stalled four cycles
        out_ready = 1'b0;
        fork
            begin
                repeat (6) send_rand();
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Random stream with random output backpressure
        rand_done = 1'b0;
        fork
            begin
                repeat (300) send_rand();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("drain_random");

        // Reset mid-stream: two items in flight are discarded
        out_ready = 1'b0;
        send_rand();
        send_rand();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        chk("postrst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(0, 7'd1, 4'd0, 57'h0, 0, 0, 1, 64'h40F0_0000_0000_0000, 0);
        drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
